// File: rtl/regfile_wb_queue.sv
// Writeback queue: merges ALU (A) and load/multi-cycle (B) results, drains one register-file write per cycle.
// Forwarding lookups search the queued entries plus the output register, and the youngest match wins.
module regfile_wb_queue #(
  parameter int DEPTH = 4,
  parameter int DW    = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       a_valid,
  output logic                       a_ready,
  input  logic [4:0]                 a_rd,
  input  logic [DW-1:0]              a_data,
  input  logic                       b_valid,
  output logic                       b_ready,
  input  logic [4:0]                 b_rd,
  input  logic [DW-1:0]              b_data,
  output logic                       W_en,
  output logic [4:0]                 Rd,
  output logic [DW-1:0]              Wr_data,
  input  logic [4:0]                 q_rs1,
  input  logic [4:0]                 q_rs2,
  output logic                       q_hit1,
  output logic                       q_hit2,
  output logic [DW-1:0]              q_data1,
  output logic [DW-1:0]              q_data2,
  output logic [$clog2(DEPTH):0]     count
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [4:0]    mem_rd   [DEPTH];
  logic [DW-1:0] mem_data [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr, b_idx;
  logic [CW-1:0] free;
  logic          a_push, b_push, pop;

  // Readiness uses the pre-pop count, so a same-cycle pop never frees a slot.
  assign free    = CW'(DEPTH) - count;
  assign a_ready = (free != '0);
  assign b_ready = (free >= CW'(2)) | ((free != '0) & ~a_valid);

  // rd==0 transfers are accepted but dropped.
  assign a_push = a_valid & a_ready & (a_rd != 5'd0);
  assign b_push = b_valid & b_ready & (b_rd != 5'd0);
  assign pop    = (count != '0);
  assign b_idx  = wr_ptr + PW'(a_push);

  always_ff @(posedge clk) begin
    if (a_push) begin
      mem_rd[wr_ptr]   <= a_rd;
      mem_data[wr_ptr] <= a_data;
    end
    if (b_push) begin
      mem_rd[b_idx]   <= b_rd;
      mem_data[b_idx] <= b_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      W_en    <= 1'b0;
      Rd      <= 5'd0;
      Wr_data <= '0;
    end else begin
      wr_ptr <= wr_ptr + PW'(a_push) + PW'(b_push);
      count  <= count + CW'(a_push) + CW'(b_push) - CW'(pop);
      W_en   <= pop;
      if (pop) begin
        rd_ptr  <= rd_ptr + PW'(1);
        Rd      <= mem_rd[rd_ptr];
        Wr_data <= mem_data[rd_ptr];
      end
    end
  end

  // Walk from the output register (oldest) through the queue head to tail; later matches override.
  function automatic logic [DW:0] lookup(input logic [4:0] rs);
    logic          hit;
    logic [DW-1:0] dat;
    logic [PW-1:0] idx;
    hit = 1'b0;
    dat = '0;
    idx = '0;
    if (rs != 5'd0) begin
      if (W_en && (Rd == rs)) begin
        hit = 1'b1;
        dat = Wr_data;
      end
      for (int i = 0; i < DEPTH; i++) begin
        idx = rd_ptr + PW'(i);
        if ((CW'(i) < count) && (mem_rd[idx] == rs)) begin
          hit = 1'b1;
          dat = mem_data[idx];
        end
      end
    end
    return {hit, dat};
  endfunction

  assign {q_hit1, q_data1} = lookup(q_rs1);
  assign {q_hit2, q_data2} = lookup(q_rs2);
endmodule

// File: tb/tb_regfile_wb_queue.sv
// Directed bench for regfile_wb_queue: per-feature tasks with hand-computed expectations and a small order model.
module tb_regfile_wb_queue;
  logic        clk, rst;
  logic        a_valid, a_ready, b_valid, b_ready;
  logic [4:0]  a_rd, b_rd, Rd, q_rs1, q_rs2;
  logic [31:0] a_data, b_data, Wr_data, q_data1, q_data2;
  logic        W_en, q_hit1, q_hit2;
  logic [2:0]  count;
  int          n_cmp = 0;
  int          n_fail = 0;

  regfile_wb_queue #(.DEPTH(4), .DW(32)) dut (
    .clk(clk), .rst(rst),
    .a_valid(a_valid), .a_ready(a_ready), .a_rd(a_rd), .a_data(a_data),
    .b_valid(b_valid), .b_ready(b_ready), .b_rd(b_rd), .b_data(b_data),
    .W_en(W_en), .Rd(Rd), .Wr_data(Wr_data),
    .q_rs1(q_rs1), .q_rs2(q_rs2), .q_hit1(q_hit1), .q_hit2(q_hit2),
    .q_data1(q_data1), .q_data2(q_data2), .count(count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs;
    a_valid = 1'b0; b_valid = 1'b0;
    a_rd = 5'd0; b_rd = 5'd0; a_data = '0; b_data = '0;
  endtask

  task automatic test_reset;
    idle_inputs();
    q_rs1 = 5'd0; q_rs2 = 5'd0;
    rst = 1'b1;
    #12;
    n_cmp++; if ({a_ready, b_ready} !== 2'b11) begin n_fail++; $display("FAIL reset_ready: got %b exp 11", {a_ready, b_ready}); end
    n_cmp++; if ({W_en, Rd, Wr_data} !== 38'd0) begin n_fail++; $display("FAIL reset_wr: got en=%b rd=%0d d=%h exp 0", W_en, Rd, Wr_data); end
    n_cmp++; if (count !== 3'd0) begin n_fail++; $display("FAIL reset_count: got %0d exp 0", count); end
    n_cmp++; if ({q_hit1, q_hit2, q_data1, q_data2} !== 66'd0) begin n_fail++; $display("FAIL reset_fwd: got %b%b %h %h exp 0", q_hit1, q_hit2, q_data1, q_data2); end
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_single_write;
    a_valid = 1'b1; a_rd = 5'd5; a_data = 32'h1111_1111;
    step();
    idle_inputs();
    n_cmp++; if ({W_en, count} !== {1'b0, 3'd1}) begin n_fail++; $display("FAIL single_accept: got en=%b cnt=%0d exp en=0 cnt=1", W_en, count); end
    step();
    n_cmp++; if ({W_en, Rd, Wr_data} !== {1'b1, 5'd5, 32'h1111_1111}) begin n_fail++; $display("FAIL single_write: got en=%b rd=%0d d=%h exp 1 5 11111111", W_en, Rd, Wr_data); end
    n_cmp++; if (count !== 3'd0) begin n_fail++; $display("FAIL single_count: got %0d exp 0", count); end
    step();
    n_cmp++; if ({W_en, Rd} !== {1'b0, 5'd5}) begin n_fail++; $display("FAIL single_hold: got en=%b rd=%0d exp en=0 rd=5", W_en, Rd); end
  endtask

  task automatic test_dual_push;
    a_valid = 1'b1; a_rd = 5'd3; a_data = 32'hA;
    b_valid = 1'b1; b_rd = 5'd3; b_data = 32'hB;
    q_rs1 = 5'd3;
    #1;
    n_cmp++; if ({a_ready, b_ready} !== 2'b11) begin n_fail++; $display("FAIL dual_ready: got %b exp 11", {a_ready, b_ready}); end
    step();
    idle_inputs();
    n_cmp++; if (count !== 3'd2) begin n_fail++; $display("FAIL dual_count: got %0d exp 2", count); end
    n_cmp++; if ({q_hit1, q_data1} !== {1'b1, 32'hB}) begin n_fail++; $display("FAIL dual_fwd_q: got %b %h exp 1 b", q_hit1, q_data1); end
    step();
    n_cmp++; if ({W_en, Rd, Wr_data} !== {1'b1, 5'd3, 32'hA}) begin n_fail++; $display("FAIL dual_first: got en=%b rd=%0d d=%h exp 1 3 a", W_en, Rd, Wr_data); end
    n_cmp++; if ({q_hit1, q_data1} !== {1'b1, 32'hB}) begin n_fail++; $display("FAIL dual_fwd_young: got %b %h exp 1 b", q_hit1, q_data1); end
    step();
    n_cmp++; if ({W_en, Rd, Wr_data} !== {1'b1, 5'd3, 32'hB}) begin n_fail++; $display("FAIL dual_second: got en=%b rd=%0d d=%h exp 1 3 b", W_en, Rd, Wr_data); end
    step();
    n_cmp++; if ({W_en, count, q_hit1, q_data1} !== {1'b0, 3'd0, 1'b0, 32'h0}) begin n_fail++; $display("FAIL dual_done: got en=%b cnt=%0d hit=%b d=%h exp 0 0 0 0", W_en, count, q_hit1, q_data1); end
  endtask

  task automatic test_rd0_filter;
    a_valid = 1'b1; a_rd = 5'd0; a_data = 32'hDEAD;
    q_rs1 = 5'd0;
    #1;
    n_cmp++; if (a_ready !== 1'b1) begin n_fail++; $display("FAIL rd0_ready: got %b exp 1", a_ready); end
    step();
    idle_inputs();
    n_cmp++; if (count !== 3'd0) begin n_fail++; $display("FAIL rd0_count: got %0d exp 0", count); end
    n_cmp++; if ({q_hit1, q_data1} !== 33'd0) begin n_fail++; $display("FAIL rd0_fwd: got %b %h exp 0 0", q_hit1, q_data1); end
    for (int i = 0; i < 3; i++) begin
      n_cmp++; if (W_en !== 1'b0) begin n_fail++; $display("FAIL rd0_wen: cycle %0d got %b exp 0", i, W_en); end
      step();
    end
  endtask

  task automatic test_fwd_outreg;
    q_rs2 = 5'd7;
    a_valid = 1'b1; a_rd = 5'd7; a_data = 32'h77;
    step();
    idle_inputs();
    n_cmp++; if ({q_hit2, q_data2} !== {1'b1, 32'h77}) begin n_fail++; $display("FAIL fwd_queue: got %b %h exp 1 77", q_hit2, q_data2); end
    step();
    n_cmp++; if ({W_en, q_hit2, q_data2} !== {1'b1, 1'b1, 32'h77}) begin n_fail++; $display("FAIL fwd_outreg: got en=%b hit=%b d=%h exp 1 1 77", W_en, q_hit2, q_data2); end
    step();
    n_cmp++; if ({q_hit2, q_data2} !== 33'd0) begin n_fail++; $display("FAIL fwd_after: got %b %h exp 0 0", q_hit2, q_data2); end
    q_rs2 = 5'd0;
  endtask

  task automatic test_backpressure;
    logic [36:0] mq[$];
    logic [36:0] exp_w;
    int          mc;
    logic        av, bv, m_ar, m_br, acc_a, acc_b, m_pop;
    mc = 0;
    for (int i = 0; i < 20; i++) begin
      av = ((i % 3) != 2);
      bv = ((i % 4) != 3);
      a_valid = av; a_rd = 5'(i % 31 + 1);       a_data = 32'hA000_0000 + 32'(i);
      b_valid = bv; b_rd = 5'((i + 7) % 31 + 1); b_data = 32'hB000_0000 + 32'(i);
      #1;
      m_ar = (4 - mc) >= 1;
      m_br = ((4 - mc) >= 2) || (((4 - mc) >= 1) && !av);
      n_cmp++; if ({a_ready, b_ready} !== {m_ar, m_br}) begin n_fail++; $display("FAIL bp_ready: cyc %0d cnt %0d got %b exp %b", i, mc, {a_ready, b_ready}, {m_ar, m_br}); end
      acc_a = av && m_ar;
      acc_b = bv && m_br;
      step();
      m_pop = (mc > 0);
      if (m_pop) exp_w = mq.pop_front();
      if (acc_a) mq.push_back({a_rd, a_data});
      if (acc_b) mq.push_back({b_rd, b_data});
      mc = mc + int'(acc_a) + int'(acc_b) - int'(m_pop);
      n_cmp++; if (count !== 3'(mc)) begin n_fail++; $display("FAIL bp_count: cyc %0d got %0d exp %0d", i, count, mc); end
      n_cmp++; if (W_en !== m_pop || (m_pop && {Rd, Wr_data} !== exp_w)) begin n_fail++; $display("FAIL bp_write: cyc %0d got en=%b %h exp en=%b %h", i, W_en, {Rd, Wr_data}, m_pop, exp_w); end
    end
    idle_inputs();
    for (int i = 0; i < 8 && mc > 0; i++) begin
      step();
      exp_w = mq.pop_front();
      mc--;
      n_cmp++; if (W_en !== 1'b1 || {Rd, Wr_data} !== exp_w) begin n_fail++; $display("FAIL bp_drain: got en=%b %h exp en=1 %h", W_en, {Rd, Wr_data}, exp_w); end
    end
    step();
    n_cmp++; if ({W_en, count} !== {1'b0, 3'd0} || mc != 0) begin n_fail++; $display("FAIL bp_empty: got en=%b cnt=%0d model=%0d exp 0 0 0", W_en, count, mc); end
  endtask

  task automatic test_async_reset;
    a_valid = 1'b1; a_rd = 5'd10; a_data = 32'h10;
    b_valid = 1'b1; b_rd = 5'd11; b_data = 32'h11;
    step();
    a_rd = 5'd12; a_data = 32'h12; b_rd = 5'd13; b_data = 32'h13;
    #1;
    n_cmp++; if (b_ready !== 1'b1) begin n_fail++; $display("FAIL ar_bready2: got %b exp 1", b_ready); end
    step();
    n_cmp++; if ({W_en, count} !== {1'b1, 3'd3}) begin n_fail++; $display("FAIL ar_fill: got en=%b cnt=%0d exp 1 3", W_en, count); end
    #1;
    n_cmp++; if ({a_ready, b_ready} !== 2'b10) begin n_fail++; $display("FAIL ar_bready3: got %b exp 10", {a_ready, b_ready}); end
    a_valid = 1'b0;
    #1;
    n_cmp++; if (b_ready !== 1'b1) begin n_fail++; $display("FAIL ar_bready3_noa: got %b exp 1", b_ready); end
    idle_inputs();
    rst = 1'b1;
    #1;
    n_cmp++; if ({W_en, count, Rd} !== {1'b0, 3'd0, 5'd0}) begin n_fail++; $display("FAIL ar_immediate: got en=%b cnt=%0d rd=%0d exp 0 0 0", W_en, count, Rd); end
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      n_cmp++; if ({W_en, count} !== {1'b0, 3'd0}) begin n_fail++; $display("FAIL ar_after: cyc %0d got en=%b cnt=%0d exp 0 0", i, W_en, count); end
    end
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_dual_push();
    test_rd0_filter();
    test_fwd_outreg();
    test_backpressure();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
